mont_seq: RTL and testbench

MONT_SEQ -- requirements
Module: mont_seq

---
 rtl/mont_seq.sv | 137 +++++++++++++
 tb/tb_mont_seq.sv | 343 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mont_seq.sv
// Sequencer for a bit-serial Montgomery product A*B*2^-512 mod M.
// It drives an external mpadder and reads back its accumulator sign, parity and carry state.
module mont_seq (
   input  logic         clk,
   input  logic         resetn,
   input  logic         start,
   input  logic [511:0] op_a,
   input  logic [511:0] op_b,
   input  logic [511:0] op_m,
   input  logic         acc_lsb,
   input  logic         acc_msb,
   input  logic         c_zero,
   output logic [513:0] add_operand,
   output logic         add_subtract,
   output logic         add_shift,
   output logic         add_enable_c,
   output logic         acc_clear,
   output logic         busy,
   output logic         done
);

   typedef enum logic [3:0] {
      StIdle,
      StLoad,
      StAddA,
      StAddM,
      StRes1,
      StSub,
      StRes2,
      StCheck,
      StRestore,
      StRes3,
      StFin
   } state_e;

   state_e       state_q, state_d;
   logic [511:0] a_q, a_d;
   logic [511:0] b_q, b_d;
   logic [511:0] m_q, m_d;
   logic [8:0]   i_q, i_d;
   logic         p_q, p_d;

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_q <= StIdle;
         a_q     <= '0;
         b_q     <= '0;
         m_q     <= '0;
         i_q     <= '0;
         p_q     <= 1'b0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         m_q     <= m_d;
         i_q     <= i_d;
         p_q     <= p_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      a_d          = a_q;
      b_d          = b_q;
      m_d          = m_q;
      i_d          = i_q;
      p_d          = p_q;
      add_operand  = '0;
      add_subtract = 1'b0;
      add_shift    = 1'b0;
      add_enable_c = 1'b0;
      acc_clear    = 1'b0;
      done         = 1'b0;
      busy         = (state_q != StIdle);

      unique case (state_q)
         StIdle: begin
            if (start) begin
               a_d     = op_a;
               b_d     = op_b;
               m_d     = op_m;
               i_d     = '0;
               p_d     = 1'b0;
               state_d = StLoad;
            end
         end
         StLoad: begin
            acc_clear = 1'b1;
            state_d   = StAddA;
         end
         StAddA: begin
            if (b_q[0]) add_operand = {2'b00, a_q};
            add_enable_c = 1'b1;
            // Parity of the accumulator once this add lands decides whether M is added next.
            p_d     = acc_lsb ^ (b_q[0] & a_q[0]);
            state_d = StAddM;
         end
         StAddM: begin
            if (p_q) add_operand = {2'b00, m_q};
            add_enable_c = 1'b1;
            add_shift    = 1'b1;
            b_d          = {1'b0, b_q[511:1]};
            i_d          = i_q + 9'd1;
            state_d      = (i_q == 9'd511) ? StRes1 : StAddA;
         end
         StRes1: begin
            if (c_zero) state_d = StSub;
         end
         StSub: begin
            add_operand  = {2'b00, m_q};
            add_subtract = 1'b1;
            add_enable_c = 1'b1;
            state_d      = StRes2;
         end
         StRes2: begin
            if (c_zero) state_d = StCheck;
         end
         StCheck: begin
            state_d = acc_msb ? StRestore : StFin;
         end
         StRestore: begin
            add_operand  = {2'b00, m_q};
            add_enable_c = 1'b1;
            state_d      = StRes3;
         end
         StRes3: begin
            if (c_zero) state_d = StFin;
         end
         StFin: begin
            done    = 1'b1;
            state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

endmodule

// File: tb/tb_mont_seq.sv
// Randomised bench for mont_seq with a behavioural mpadder and a whole-operation reference model.
// Every adder command is compared in order against the model's expected command list.
module tb_mont_seq;

   typedef struct {
      int           kind;  // 0 clear, 1 add A, 2 add M+shift, 3 sub, 4 restore
      logic         clr;
      logic         sub;
      logic         shift;
      logic [513:0] opnd;
   } op_t;

   logic         clk = 1'b0;
   logic         resetn, start;
   logic [511:0] op_a, op_b, op_m;
   logic         acc_lsb, acc_msb, c_zero;
   logic [513:0] add_operand;
   logic         add_subtract, add_shift, add_enable_c, acc_clear, busy, done;

   logic [513:0] acc;
   op_t          exp_q[$];
   logic [513:0] exp_res, last_res;
   logic [513:0] log_opnd[4];
   logic [1:0]   log_ctl[4];
   int           log_n, en_cnt, add_m_cnt, done_cnt, txn_done, cz_mode;
   int           checks = 0;
   int           failures = 0;
   bit           chk_en = 1'b0;

   mont_seq dut (
      .clk          (clk),
      .resetn       (resetn),
      .start        (start),
      .op_a         (op_a),
      .op_b         (op_b),
      .op_m         (op_m),
      .acc_lsb      (acc_lsb),
      .acc_msb      (acc_msb),
      .c_zero       (c_zero),
      .add_operand  (add_operand),
      .add_subtract (add_subtract),
      .add_shift    (add_shift),
      .add_enable_c (add_enable_c),
      .acc_clear    (acc_clear),
      .busy         (busy),
      .done         (done)
   );

   always #5 clk = ~clk;

   initial begin
      #900000;
      $display("FAIL global_timeout actual=running required=finished");
      $fatal(1);
   end

   // Behavioural mpadder: always carry-resolved, so c_zero is free stimulus.
   assign acc_lsb = acc[0];
   assign acc_msb = acc[513];
   always @(posedge clk) begin
      if (acc_clear) acc <= '0;
      else if (add_enable_c) begin
         if (add_subtract) acc <= acc - add_operand;
         else if (add_shift) acc <= (acc + add_operand) >> 1;
         else acc <= acc + add_operand;
      end
   end

   always @(negedge clk) begin
      if (cz_mode == 1) c_zero = 1'b0;
      else if (cz_mode == 2) c_zero = 1'b1;
      else c_zero = ($urandom_range(0, 3) != 0);
   end

   task automatic chk(input string name, input logic [519:0] act, input logic [519:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   task automatic push(input int kind, input logic clr, input logic sub, input logic shift,
                       input logic [513:0] opnd);
      op_t e;
      e.kind  = kind;
      e.clr   = clr;
      e.sub   = sub;
      e.shift = shift;
      e.opnd  = opnd;
      exp_q.push_back(e);
   endtask

   // Interleaved Montgomery loop on plain integers; yields the adder command list and result.
   task automatic build(input logic [511:0] a, input logic [511:0] b, input logic [511:0] m,
                        output logic [513:0] res);
      logic [515:0] s;
      exp_q.delete();
      push(0, 1'b1, 1'b0, 1'b0, '0);
      s = '0;
      for (int k = 0; k < 512; k++) begin
         push(1, 1'b0, 1'b0, 1'b0, b[k] ? {2'b00, a} : 514'd0);
         if (b[k]) s = s + 516'(a);
         push(2, 1'b0, 1'b0, 1'b1, s[0] ? {2'b00, m} : 514'd0);
         if (s[0]) s = s + 516'(m);
         s = s >> 1;
      end
      push(3, 1'b0, 1'b1, 1'b0, {2'b00, m});
      if (s < 516'(m)) begin
         push(4, 1'b0, 1'b0, 1'b0, {2'b00, m});
         res = s[513:0];
      end else begin
         s   = s - 516'(m);
         res = s[513:0];
      end
   endtask

   // Independent reference: full product followed by bitwise REDC.
   function automatic logic [513:0] redc_ref(input logic [511:0] a, input logic [511:0] b,
                                             input logic [511:0] m);
      logic [1025:0] t;
      t = 1026'(a) * 1026'(b);
      for (int k = 0; k < 512; k++) begin
         if (t[0]) t = t + 1026'(m);
         t = t >> 1;
      end
      if (t >= 1026'(m)) t = t - 1026'(m);
      return t[513:0];
   endfunction

   function automatic logic mont_ok(input logic [513:0] r, input logic [511:0] a,
                                    input logic [511:0] b, input logic [511:0] m);
      logic [1535:0] mm, lhs, rhs;
      mm  = 1536'(m);
      lhs = (1536'(r) << 512) % mm;
      rhs = (1536'(a) * 1536'(b)) % mm;
      return (lhs == rhs) && (r < 514'(m));
   endfunction

   function automatic logic [511:0] rnd512();
      logic [511:0] r;
      for (int k = 0; k < 16; k++) r[32*k +: 32] = $urandom;
      return r;
   endfunction

   always @(negedge clk) begin
      op_t e;
      if (chk_en) begin
         if (!busy) begin
            chk("idle_outputs", 520'({add_operand, add_subtract, add_shift, add_enable_c,
                                      acc_clear, done}), '0);
         end else if (acc_clear | add_enable_c | add_subtract | add_shift) begin
            if (exp_q.size() == 0) chk("unexpected_op", 520'(1), 520'(0));
            else begin
               e = exp_q.pop_front();
               chk("op_ctrl", 520'({acc_clear, add_subtract, add_shift, add_enable_c}),
                   520'({e.clr, e.sub, e.shift, ~e.clr}));
               chk("op_operand", 520'(add_operand), 520'(e.opnd));
            end
            if (log_n < 4) begin
               log_opnd[log_n] = add_operand;
               log_ctl[log_n]  = {acc_clear, add_shift};
               log_n++;
            end
            if (add_enable_c) en_cnt++;
            if (add_shift) add_m_cnt++;
         end else begin
            chk("quiet_operand", 520'(add_operand), '0);
         end
         if (done) begin
            done_cnt++;
            last_res = acc;
            chk("done_queue_empty", 520'(exp_q.size()), '0);
            chk("result", 520'(acc), 520'(exp_res));
         end
      end
   end

   task automatic launch(input logic [511:0] a, input logic [511:0] b, input logic [511:0] m);
      logic [513:0] r;
      int n = 0;
      while (busy && n < 5000) begin
         @(posedge clk);
         #1;
         n++;
      end
      chk("launch_idle", 520'(busy), '0);
      build(a, b, m, r);
      chk("model_vs_redc", 520'(r), 520'(redc_ref(a, b, m)));
      chk("model_identity", 520'(mont_ok(r, a, b, m)), 520'(1));
      exp_res   = r;
      log_n     = 0;
      en_cnt    = 0;
      add_m_cnt = 0;
      txn_done  = done_cnt;
      op_a      = a;
      op_b      = b;
      op_m      = m;
      start     = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      op_a  = rnd512();
      op_b  = rnd512();
      op_m  = rnd512();
   endtask

   task automatic wait_done(input string name);
      int n = 0;
      bit dropped = 1'b0;
      while (done_cnt == txn_done && n < 4000) begin
         @(posedge clk);
         #1;
         n++;
         if (done_cnt == txn_done && !busy) dropped = 1'b1;
      end
      chk({name, "_done_seen"}, 520'(done_cnt != txn_done), 520'(1));
      chk({name, "_busy_held"}, 520'(dropped), '0);
      repeat (3) begin
         @(posedge clk);
         #1;
      end
      chk({name, "_done_once"}, 520'(done_cnt - txn_done), 520'(1));
   endtask

   task automatic wait_en(input int target);
      int n = 0;
      while (en_cnt < target && n < 3000) begin
         @(posedge clk);
         #1;
         n++;
      end
      chk("wait_en_reached", 520'(en_cnt >= target), 520'(1));
   endtask

   initial begin
      logic [511:0] a, b, m;
      int d0;
      resetn   = 1'b0;
      start    = 1'b0;
      op_a     = '0;
      op_b     = '0;
      op_m     = '0;
      cz_mode  = 0;
      done_cnt = 0;
      log_n    = 4;
      en_cnt   = 0;
      repeat (3) @(posedge clk);
      #1;
      chk_en = 1'b1;
      @(posedge clk);
      #1;
      chk("reset_busy", 520'(busy), '0);
      chk("reset_outputs", 520'({add_operand, add_subtract, add_shift, add_enable_c,
                                 acc_clear, done}), '0);
      resetn = 1'b1;

      // Pin the reference itself: 5 * 2^-512 mod 7 = 3.
      chk("ref_pin_5_1_7", 520'(redc_ref(512'd5, 512'd1, 512'd7)), 520'(3));

      launch(512'd5, 512'd1, 512'd7);
      wait_done("t_small");
      chk("t_small_load", 520'({log_ctl[0], log_opnd[0]}), 520'({2'b10, 514'd0}));
      chk("t_small_adda0", 520'({log_ctl[1], log_opnd[1]}), 520'({2'b00, 514'd5}));
      chk("t_small_addm0", 520'({log_ctl[2], log_opnd[2]}), 520'({2'b01, 514'd7}));
      chk("t_small_adda1", 520'({log_ctl[3], log_opnd[3]}), 520'({2'b00, 514'd0}));
      chk("t_small_result", 520'(last_res), 520'(3));

      m = rnd512() | 512'd1;
      launch('0, '0, m);
      wait_done("t_zero");
      chk("t_zero_enables", 520'(en_cnt), 520'(1026));
      chk("t_zero_result", 520'(last_res), '0);

      a = {1'b0, {511{1'b1}}};
      m = '1;
      launch(a, a, m);
      wait_en(1023);
      cz_mode = 1;
      @(posedge clk);
      #1;
      repeat (20) begin
         @(posedge clk);
         #1;
         chk("res1_hold", 520'({busy, add_enable_c, add_subtract}), 520'(3'b100));
      end
      cz_mode = 2;
      @(posedge clk);
      #1;
      chk("res1_release_sub", 520'({add_enable_c, add_subtract}), 520'(2'b11));
      cz_mode = 0;
      wait_done("t_max");
      chk("t_max_addm_count", 520'(add_m_cnt), 520'(512));
      chk("t_max_result_ref", 520'(last_res), 520'(redc_ref(a, a, m)));

      m = rnd512() | 512'd1;
      a = rnd512() % m;
      b = rnd512() % m;
      launch(a, b, m);
      wait_en(300);
      start = 1'b1;
      op_a  = rnd512();
      op_b  = rnd512();
      op_m  = rnd512() | 512'd1;
      @(posedge clk);
      #1;
      start = 1'b0;
      wait_done("t_restart");
      chk("t_restart_result_ref", 520'(last_res), 520'(redc_ref(a, b, m)));

      m = rnd512() | 512'd1;
      launch(rnd512() % m, rnd512() % m, m);
      wait_en(600);
      resetn = 1'b0;
      d0     = done_cnt;
      @(posedge clk);
      #1;
      resetn = 1'b1;
      exp_q.delete();
      chk("abort_busy", 520'(busy), '0);
      chk("abort_outputs", 520'({add_operand, add_subtract, add_shift, add_enable_c,
                                 acc_clear, done}), '0);
      repeat (5) begin
         @(posedge clk);
         #1;
      end
      chk("abort_no_done", 520'(done_cnt), 520'(d0));
      m = rnd512() | 512'd1;
      launch(rnd512() % m, rnd512() % m, m);
      wait_done("t_after_abort");

      for (int t = 0; t < 4; t++) begin
         m = rnd512() | 512'd1;
         if (t == 0) m[511] = 1'b1;
         launch(rnd512() % m, rnd512() % m, m);
         wait_done("t_rand");
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
